c2_host_initiator: RTL
======================

// Module: c2_host_initiator
// PURPOSE
// - On-chip initiator for the C2 UART command protocol: issues a command byte, checks the byte-for-byte echo ACK, then streams N payload bytes.
// - Sits between an autoboot/self-test sequencer (request + payload stream) and a UART TX/RX pair cross-wired to the C2 responder.
// - Forwards every RX byte received after the ACK (loader/dumper traffic) to rx_* and reports a completion status.
// PARAMETERS
// - LEN_W               16         payload length counter width (max 2^LEN_W-1 bytes)
// - ACK_TIMEOUT_CYCLES  1_000_000  clk_i cycles allowed from command TX done to echo arrival (C2_ACK_TIMEOUT_EN only)
// PORTS
// - clk_i           in   1      clock
// - rst_ni          in   1      reset, asynchronous, active-low
// - req_valid_i     in   1      request valid
// - req_ready_o     out  1      request accepted when valid&&ready
// - req_cmd_i       in   8      command byte: 0x1C, 0x1D, 0xCE or 0xDE
// - req_len_i       in   LEN_W  payload byte count; 0 allowed
// - pay_data_i      in   8      payload byte
// - pay_valid_i     in   1      payload byte valid
// - pay_ready_o     out  1      payload byte consumed when valid&&ready
// - uart_tx_data_o  out  8      TX byte; held stable from start until done
// - uart_tx_start_o out  1      one-cycle TX start pulse
// - uart_tx_done_i  in   1      one-cycle pulse: TX byte fully sent
// - uart_rx_data_i  in   8      RX byte
// - uart_rx_ready_i in   1      one-cycle pulse: RX byte valid
// - rx_data_o       out  8      forwarded RX byte (post-ACK)
// - rx_valid_o      out  1      one-cycle pulse with rx_data_o
// - rsp_valid_o     out  1      one-cycle completion pulse
// - rsp_status_o    out  2      0=OK 1=NACK(echo mismatch) 2=TIMEOUT 3=BADCMD; held until next rsp_valid_o
// - busy_o          out  1      high in every state except S_IDLE
// BEHAVIOUR
// - Reset: state=S_IDLE; req_ready_o=1; all other outputs 0 (uart_tx_data_o=0x00, rsp_status_o=0).
// - S_IDLE: req_ready_o=1. On accept, latch cmd and len. Invalid cmd -> S_RESP with BADCMD; no TX occurs. Valid cmd -> S_CMD_TX.
// - S_CMD_TX: drive uart_tx_data_o=cmd and uart_tx_start_o=1 for exactly one cycle -> S_CMD_WAIT.
// - S_CMD_WAIT: wait for uart_tx_done_i -> S_ACK_WAIT. An RX byte in this state is latched as the echo; the responder may complete its echo before local TX done is seen.
// - S_ACK_WAIT: when an echo is latched or arrives: equal to cmd -> S_PAY_FETCH (or S_RESP OK if len==0); unequal -> S_RESP NACK.
// - S_PAY_FETCH: pay_ready_o=1. On pay_valid_i, latch byte -> S_PAY_TX.
// - S_PAY_TX: one-cycle start pulse -> S_PAY_WAIT. On uart_tx_done_i, decrement remaining count: 0 -> S_RESP OK, else -> S_PAY_FETCH.
// - Payload stall: no timeout applies while waiting on pay_valid_i.
// - Forwarding: in S_PAY_FETCH/S_PAY_TX/S_PAY_WAIT/S_RESP, each uart_rx_ready_i produces rx_valid_o one cycle later with the byte. The echo byte is never forwarded.
// - S_RESP: rsp_valid_o=1 for one cycle; update rsp_status_o -> S_IDLE.
// - Exactly one TX start per byte. Never pulse start before the previous done.
// - Simultaneous uart_tx_done_i and uart_rx_ready_i: both are honoured in the same cycle.
// - Async reset mid-transfer aborts immediately with no rsp_valid_o. The UART peripheral is not flushed.
// CONFIGURATION
// - C2_ACK_TIMEOUT_EN defined:
//   - A counter clears on entry to S_ACK_WAIT and increments each cycle there.
//   - Reaching ACK_TIMEOUT_CYCLES-1 with no echo -> S_RESP TIMEOUT.
//   - An echo arriving on the final count cycle wins, giving OK or NACK.
// - Not defined: S_ACK_WAIT waits indefinitely; the counter and ACK_TIMEOUT_CYCLES are unused; TIMEOUT is never reported.
// STRUCTURE
// - c2_pkg (shared with the C2 responder):
//   - CMD_LOAD_CODE/CMD_LOAD_DATA/CMD_CONT_EXEC/CMD_DEBUG_EXEC constants
//   - c2_status_t enum {C2_OK, C2_NACK, C2_TIMEOUT, C2_BADCMD}
//   - is_valid_cmd() function
// - Single module, no sub-modules. The FSM, payload down-counter, echo latch and timeout counter all sit inline.
// TESTING
// - Normal load: cmd 0x1C, len 3, payload A1 B2 C3, loopback echo 0x1C -> TX sequence 1C A1 B2 C3; then rsp OK.
// - Len 0: cmd 0xCE with echo 0xCE -> only 1C-style single TX byte (0xCE); then rsp OK. pay_ready_o never asserted.
// - Mismatched echo: cmd 0x1D, echo 0x55 -> rsp NACK; no payload TX; pay_ready_o stays 0.
// - Bad cmd 0x42: rsp BADCMD on the cycle after accept; uart_tx_start_o never pulses.
// - Early echo plus forwarding: echo 0xDE arrives before uart_tx_done_i -> accepted. Later RX bytes 0x10, 0x20 appear on rx_data_o, the echo does not.
// - Timeout (C2_ACK_TIMEOUT_EN, ACK_TIMEOUT_CYCLES=16): no echo -> rsp TIMEOUT 16 cycles after entering S_ACK_WAIT.
// - Mid-payload reset: assert rst_ni low during S_PAY_WAIT -> all outputs at reset values; no rsp_valid_o.

Source files
------------

// File: rtl/c2_pkg.sv
// Shared C2 protocol definitions: command bytes, completion status codes and
// command validation. Used by both the C2 host initiator and the responder.
package c2_pkg;

    localparam logic [7:0] CMD_LOAD_CODE  = 8'h1C;
    localparam logic [7:0] CMD_LOAD_DATA  = 8'h1D;
    localparam logic [7:0] CMD_CONT_EXEC  = 8'hCE;
    localparam logic [7:0] CMD_DEBUG_EXEC = 8'hDE;

    typedef enum logic [1:0] {
        C2_OK      = 2'd0,
        C2_NACK    = 2'd1,
        C2_TIMEOUT = 2'd2,
        C2_BADCMD  = 2'd3
    } c2_status_t;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd == CMD_LOAD_CODE)  || (cmd == CMD_LOAD_DATA) ||
               (cmd == CMD_CONT_EXEC)  || (cmd == CMD_DEBUG_EXEC);
    endfunction

endpackage

// File: rtl/c2_host_initiator.sv
// C2 UART command initiator: sends a command byte, checks its echo, streams the
// payload and forwards post-ACK RX traffic. Define C2_ACK_TIMEOUT_EN to bound the ACK wait.
module c2_host_initiator
    import c2_pkg::*;
#(
    parameter int unsigned LEN_W              = 16,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [7:0]       req_cmd_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       pay_data_i,
    input  logic             pay_valid_i,
    output logic             pay_ready_o,
    output logic [7:0]       uart_tx_data_o,
    output logic             uart_tx_start_o,
    input  logic             uart_tx_done_i,
    input  logic [7:0]       uart_rx_data_i,
    input  logic             uart_rx_ready_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             rsp_valid_o,
    output logic [1:0]       rsp_status_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_TX, S_CMD_WAIT, S_ACK_WAIT,
        S_PAY_FETCH, S_PAY_TX, S_PAY_WAIT, S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       echo_q, echo_d;
    logic             echo_vld_q, echo_vld_d;
    c2_status_t       status_q, status_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             echo_hit;
    logic [7:0]       echo_byte;

`ifdef C2_ACK_TIMEOUT_EN
    localparam int unsigned TO_W = (ACK_TIMEOUT_CYCLES > 2) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // An echo seen during S_CMD_WAIT is held until S_ACK_WAIT; otherwise it arrives live.
    assign echo_hit  = echo_vld_q || uart_rx_ready_i;
    assign echo_byte = echo_vld_q ? echo_q : uart_rx_data_i;

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        rem_d           = rem_q;
        tx_data_d       = tx_data_q;
        echo_d          = echo_q;
        echo_vld_d      = echo_vld_q;
        status_d        = status_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        req_ready_o     = 1'b0;
        pay_ready_o     = 1'b0;
        uart_tx_start_o = 1'b0;
        rsp_valid_o     = 1'b0;
`ifdef C2_ACK_TIMEOUT_EN
        to_cnt_d        = to_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    cmd_d      = req_cmd_i;
                    rem_d      = req_len_i;
                    echo_vld_d = 1'b0;
                    if (is_valid_cmd(req_cmd_i)) begin
                        tx_data_d = req_cmd_i;
                        state_d   = S_CMD_TX;
                    end else begin
                        status_d = C2_BADCMD;
                        state_d  = S_RESP;
                    end
                end
            end
            S_CMD_TX: begin
                uart_tx_start_o = 1'b1;
                state_d         = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                if (uart_rx_ready_i && !echo_vld_q) begin
                    echo_d     = uart_rx_data_i;
                    echo_vld_d = 1'b1;
                end
                if (uart_tx_done_i) begin
                    state_d = S_ACK_WAIT;
`ifdef C2_ACK_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_ACK_WAIT: begin
`ifdef C2_ACK_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                if (echo_hit) begin
                    echo_vld_d = 1'b0;
                    if (echo_byte != cmd_q) begin
                        status_d = C2_NACK;
                        state_d  = S_RESP;
                    end else if (rem_q == '0) begin
                        status_d = C2_OK;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_PAY_FETCH;
                    end
                end
`ifdef C2_ACK_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    status_d = C2_TIMEOUT;
                    state_d  = S_RESP;
                end
`endif
            end
            S_PAY_FETCH: begin
                pay_ready_o = 1'b1;
                if (pay_valid_i) begin
                    tx_data_d = pay_data_i;
                    state_d   = S_PAY_TX;
                end
            end
            S_PAY_TX: begin
                uart_tx_start_o = 1'b1;
                state_d         = S_PAY_WAIT;
            end
            S_PAY_WAIT: begin
                if (uart_tx_done_i) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        status_d = C2_OK;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_PAY_FETCH;
                    end
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Loader/dumper traffic is forwarded only once the ACK has been consumed.
        if (uart_rx_ready_i && (state_q inside {S_PAY_FETCH, S_PAY_TX, S_PAY_WAIT, S_RESP})) begin
            rx_valid_d = 1'b1;
            rx_data_d  = uart_rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            echo_q     <= '0;
            echo_vld_q <= 1'b0;
            status_q   <= C2_OK;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef C2_ACK_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            echo_q     <= echo_d;
            echo_vld_q <= echo_vld_d;
            status_q   <= status_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef C2_ACK_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign uart_tx_data_o = tx_data_q;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign rsp_status_o   = status_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
